memory_ram_ctrl: RTL
====================

// Module: memory_ram_ctrl
// PURPOSE
//  Request-side controller for the single-port 256x32 data RAM (posedge write, negedge-registered read).
//  Accepts one load/store at a time over a valid/ready request channel and drives the RAM port.
//  Returns read data or write completion over a valid/ready response channel.
//  Sits between the datapath load/store logic and the data RAM.
// PARAMETERS
//  ADDR_W  8   RAM address width; must match RAM depth (2**ADDR_W words)
//  DATA_W  32  data word width
// PORTS
//  clk           in   1       clock; all state changes on rising edge
//  rst_n         in   1       asynchronous, active-low reset
//  req_valid     in   1       request present
//  req_ready     out  1       controller can accept a request (high only in IDLE)
//  req_we        in   1       1 = store, 0 = load
//  req_addr      in   ADDR_W  word address
//  req_wdata     in   DATA_W  store data
//  rsp_valid     out  1       response present
//  rsp_ready     in   1       consumer takes response
//  rsp_rdata     out  DATA_W  load data (0 for stores)
//  rsp_err       out  1       write-verify mismatch (only with MEMCTL_WRITE_VERIFY_EN, else 0)
//  mem_w_enable  out  1       to RAM write enable
//  mem_addr      out  ADDR_W  to RAM address
//  mem_data_in   out  DATA_W  to RAM write data
//  mem_data_out  in   DATA_W  from RAM read data (updates on falling edge)
//  busy          out  1       state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; mem_w_enable=0, mem_addr=0, mem_data_in=0, rsp_valid=0,
//   rsp_rdata=0, rsp_err=0; req_ready=1 once rst_n=1. All outputs registered except req_ready/busy (decode of state).
//  FSM states: IDLE, ACCESS, VERIFY (macro only), RESP.
//  IDLE: accept when req_valid&&req_ready at edge N: latch mem_addr<=req_addr, mem_data_in<=req_wdata,
//   mem_w_enable<=req_we, remember op; -> ACCESS. req_* ignored at all other times.
//  ACCESS (edge N+1): RAM commits store at this edge; controller drives mem_w_enable<=0.
//   Load: rsp_rdata<=mem_data_out (valid since falling edge after N), rsp_valid<=1 -> RESP.
//   Store: rsp_rdata<=0, rsp_valid<=1 -> RESP (or -> VERIFY with macro).
//  RESP: hold rsp_valid/rsp_rdata/rsp_err stable until rsp_ready; at edge with rsp_ready: rsp_valid<=0,
//   rsp_err<=0 -> IDLE. No new request accepted in the RESP cycle (one outstanding max).
//  Latency: rsp_valid high after edge N+1 (N+2 with verify); min request spacing 3 cycles (4 with verify)
//   with rsp_ready tied high.
//  mem_w_enable is high for exactly one cycle per store; never high outside ACCESS.
//  mem_addr/mem_data_in hold last request value while IDLE (no spurious toggling).
//  Address wrap: none; full range 0..2**ADDR_W-1 legal, 0 and max treated identically.
//  Reset mid-operation: store accepted but rst_n asserted before edge N+1 -> mem_w_enable drops
//   asynchronously, store not committed; pending response discarded; rsp_valid=0.
//  rsp_ready asserted while rsp_valid=0: ignored.
// CONFIGURATION
//  MEMCTL_WRITE_VERIFY_EN defined: store goes ACCESS -> VERIFY; in VERIFY (edge N+2, address held,
//   mem_w_enable=0) compare mem_data_out to mem_data_in; rsp_err<=(mismatch), rsp_valid<=1 -> RESP.
//   Loads unaffected (rsp_err=0).
//  Not defined: VERIFY state absent, rsp_err tied 0, store latency 1 cycle to rsp_valid.
// TESTING
//  Reset: rst_n=0 mid-stream -> all outputs 0, req_ready=1 after release, busy=0.
//  Store 0xDEADBEEF @0x10, then load @0x10 -> rsp_rdata=0xDEADBEEF, rsp_valid 1 cycle after accept.
//  Boundary addrs: store 0x1 @0x00 and 0x2 @0xFF, load both -> 0x1 and 0x2, no aliasing.
//  Backpressure: rsp_ready=0 for 5 cycles on load -> rsp_valid/rsp_rdata stable, req_ready=0, no new accept.
//  Reset between accept and ACCESS on store 0x55 @0x20 -> later load @0x20 returns prior value.
//  With MEMCTL_WRITE_VERIFY_EN: store 0xA5A5A5A5 @0x30 -> rsp_err=0, rsp_valid 2 cycles after accept;
//   RAM model forced to corrupt bit 0 -> rsp_err=1.

Source files
------------

// File: rtl/memory_ram_ctrl.sv
// memory_ram_ctrl: request-side controller for a single-port RAM with a posedge write
// and a negedge-registered read. It runs one load or store at a time over valid/ready
// request and response channels.
// Optional feature: define MEMCTL_WRITE_VERIFY_EN to read back every store one cycle
// after it commits and report a mismatch on rsp_err.
module memory_ram_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_w_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

`ifdef MEMCTL_WRITE_VERIFY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    VERIFY = 2'd2,
    RESP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd3
  } state_t;
`endif

  state_t              state;
  state_t              state_nxt;
  logic                op_we;
  logic                op_we_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic                we_nxt;
  logic                valid_nxt;
  logic [DATA_W-1:0]   rdata_nxt;

`ifdef MEMCTL_WRITE_VERIFY_EN
  logic                err_q;
  logic                err_nxt;
`endif

  // The only handshake signals that are not registered: both are plain decodes of the state.
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

`ifdef MEMCTL_WRITE_VERIFY_EN
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Register the state and every registered output. Reset clears the write enable at once,
  // so a store that was accepted but has not reached its commit edge is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_we        <= 1'b0;
      mem_addr     <= '0;
      mem_data_in  <= '0;
      mem_w_enable <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
`ifdef MEMCTL_WRITE_VERIFY_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      op_we        <= op_we_nxt;
      mem_addr     <= addr_nxt;
      mem_data_in  <= wdata_nxt;
      mem_w_enable <= we_nxt;
      rsp_valid    <= valid_nxt;
      rsp_rdata    <= rdata_nxt;
`ifdef MEMCTL_WRITE_VERIFY_EN
      err_q        <= err_nxt;
`endif
    end
  end

  // Next-state and next-output decode. Address and write data hold their last value unless
  // a new request is taken, and the write enable defaults low so it pulses for one cycle only.
  always_comb begin
    state_nxt = state;
    op_we_nxt = op_we;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_data_in;
    we_nxt    = 1'b0;
    valid_nxt = rsp_valid;
    rdata_nxt = rsp_rdata;
`ifdef MEMCTL_WRITE_VERIFY_EN
    err_nxt   = err_q;
`endif
    case (state)
      IDLE: begin
        if (req_valid) begin
          addr_nxt  = req_addr;
          wdata_nxt = req_wdata;
          we_nxt    = req_we;
          op_we_nxt = req_we;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (op_we) begin
          rdata_nxt = '0;
`ifdef MEMCTL_WRITE_VERIFY_EN
          state_nxt = VERIFY;
`else
          valid_nxt = 1'b1;
          state_nxt = RESP;
`endif
        end else begin
          rdata_nxt = mem_data_out;
          valid_nxt = 1'b1;
`ifdef MEMCTL_WRITE_VERIFY_EN
          err_nxt   = 1'b0;
`endif
          state_nxt = RESP;
        end
      end
`ifdef MEMCTL_WRITE_VERIFY_EN
      VERIFY: begin
        err_nxt   = (mem_data_out != mem_data_in);
        valid_nxt = 1'b1;
        state_nxt = RESP;
      end
`endif
      RESP: begin
        if (rsp_ready) begin
          valid_nxt = 1'b0;
`ifdef MEMCTL_WRITE_VERIFY_EN
          err_nxt   = 1'b0;
`endif
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
